// File: rtl/signal_ramper.sv
// Envelope ramper: scales composed samples by a Q1.15 envelope that ramps up/down
// per accepted sample, then saturates to a 14-bit signed DAC code (3-cycle latency).
module signal_ramper (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [23:0] signal_in,
   input  logic               signal_valid,
   input  logic               ramp_start,
   input  logic               ramp_stop,
   input  logic [15:0]        ramp_step,
   input  logic               sat_clear,
   output logic signed [13:0] dac_out,
   output logic               dac_valid,
   output logic [1:0]         ramp_state,
   output logic               ramp_done,
   output logic               saturated
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_HOLD = 2'd2,
      ST_DOWN = 2'd3
   } state_t;

   localparam logic [16:0]        ENV_MAX = 17'd32768;
   localparam logic signed [40:0] POS_LIM = 41'sd8191;
   localparam logic signed [40:0] NEG_LIM = -41'sd8192;

   state_t              state_q, state_d;
   logic [15:0]         env_q, env_d;
   logic                ramp_done_q, ramp_done_d;
   logic [16:0]         env_sum;

   logic signed [23:0]  s1_sample_q, s1_sample_d;
   logic [15:0]         s1_env_q, s1_env_d;
   logic                v1_q, v1_d;
   logic signed [13:0]  s2_value_q, s2_value_d;
   logic                s2_clamp_q, s2_clamp_d;
   logic                v2_q, v2_d;
   logic signed [13:0]  dac_out_q, dac_out_d;
   logic                v3_q, v3_d;
   logic                sat_q, sat_d;

   logic signed [40:0]  mul_a, mul_b, product, shifted;

   // Envelope update happens first; requests then act on the post-update state.
   always_comb begin
      env_d       = env_q;
      state_d     = state_q;
      ramp_done_d = 1'b0;
      env_sum     = {1'b0, env_q} + {1'b0, ramp_step};
      if (signal_valid && (ramp_step != '0)) begin
         case (state_q)
            ST_UP: begin
               if (env_sum >= ENV_MAX) begin
                  env_d   = ENV_MAX[15:0];
                  state_d = ST_HOLD;
               end else begin
                  env_d = env_sum[15:0];
               end
            end
            ST_DOWN: begin
               if (env_q <= ramp_step) begin
                  env_d       = '0;
                  state_d     = ST_IDLE;
                  ramp_done_d = 1'b1;
               end else begin
                  env_d = env_q - ramp_step;
               end
            end
            default: ;
         endcase
      end
      if (ramp_stop) begin
         if ((state_d == ST_UP) || (state_d == ST_HOLD)) state_d = ST_DOWN;
      end else if (ramp_start) begin
         if ((state_d == ST_IDLE) || (state_d == ST_DOWN)) state_d = ST_UP;
      end
   end

   always_comb begin
      s1_sample_d = signal_in;
      s1_env_d    = env_q;
      v1_d        = signal_valid;

      mul_a   = 41'(s1_sample_q);
      mul_b   = 41'(signed'({1'b0, s1_env_q}));
      product = mul_a * mul_b;
      shifted = product >>> 15;

      s2_clamp_d = 1'b1;
      if (shifted > POS_LIM)      s2_value_d = 14'sd8191;
      else if (shifted < NEG_LIM) s2_value_d = -14'sd8192;
      else begin
         s2_value_d = shifted[13:0];
         s2_clamp_d = 1'b0;
      end
      v2_d = v1_q;

      dac_out_d = v2_q ? s2_value_q : dac_out_q;
      v3_d      = v2_q;
      // A clamp reaching the output takes priority over a clear in the same cycle.
      if (v2_q && s2_clamp_q) sat_d = 1'b1;
      else if (sat_clear)     sat_d = 1'b0;
      else                    sat_d = sat_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         env_q       <= '0;
         ramp_done_q <= 1'b0;
         s1_sample_q <= '0;
         s1_env_q    <= '0;
         v1_q        <= 1'b0;
         s2_value_q  <= '0;
         s2_clamp_q  <= 1'b0;
         v2_q        <= 1'b0;
         dac_out_q   <= '0;
         v3_q        <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         env_q       <= env_d;
         ramp_done_q <= ramp_done_d;
         s1_sample_q <= s1_sample_d;
         s1_env_q    <= s1_env_d;
         v1_q        <= v1_d;
         s2_value_q  <= s2_value_d;
         s2_clamp_q  <= s2_clamp_d;
         v2_q        <= v2_d;
         dac_out_q   <= dac_out_d;
         v3_q        <= v3_d;
         sat_q       <= sat_d;
      end
   end

   assign dac_out    = dac_out_q;
   assign dac_valid  = v3_q;
   assign ramp_state = state_q;
   assign ramp_done  = ramp_done_q;
   assign saturated  = sat_q;

endmodule
